// File: rtl/rtc_bus_cycle.sv
// Bus-cycle engine for the external RTC: turns a single-cycle register request into a
// timed multiplexed address/data cycle (CS, AS, RD/WR strobe, recovery) and returns read data.
module rtc_bus_cycle #(
    parameter int unsigned T_ADDR = 5,
    parameter int unsigned T_AH   = 2,
    parameter int unsigned T_STB  = 15,
    parameter int unsigned T_DH   = 3,
    parameter int unsigned T_REC  = 20
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       req_i,
    input  logic       we_i,
    input  logic [7:0] addr_i,
    input  logic [7:0] wdata_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic [7:0] ad_o,
    output logic       ad_oe_o,
    input  logic [7:0] ad_i,
    output logic       as_o,
    output logic       cs_n_o,
    output logic       rd_n_o,
    output logic       wr_n_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_AHOLD, S_STROBE, S_DHOLD, S_RECOV
    } state_t;

    localparam logic [7:0] L_ADDR = (T_ADDR == 0) ? 8'd1 : 8'(T_ADDR);
    localparam logic [7:0] L_AH   = (T_AH   == 0) ? 8'd1 : 8'(T_AH);
    localparam logic [7:0] L_STB  = (T_STB  == 0) ? 8'd1 : 8'(T_STB);
    localparam logic [7:0] L_DH   = (T_DH   == 0) ? 8'd1 : 8'(T_DH);
    localparam logic [7:0] L_REC  = (T_REC  == 0) ? 8'd1 : 8'(T_REC);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       we_q;
    logic [7:0] addr_q, wdata_q;
    logic       last;

    logic       busy_d, done_d, ad_oe_d, as_d, cs_n_d, rd_n_d, wr_n_d;
    logic [7:0] ad_d, addr_src;

    function automatic logic [7:0] load_val(input state_t s);
        case (s)
            S_ADDR:   return L_ADDR;
            S_AHOLD:  return L_AH;
            S_STROBE: return L_STB;
            S_DHOLD:  return L_DH;
            S_RECOV:  return L_REC;
            default:  return 8'd1;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last      = (cnt <= 8'd1);
        case (state)
            S_IDLE:   if (req_i) state_nxt = S_ADDR;
            S_ADDR:   if (last)  state_nxt = S_AHOLD;
            S_AHOLD:  if (last)  state_nxt = S_STROBE;
            S_STROBE: if (last)  state_nxt = S_DHOLD;
            S_DHOLD:  if (last)  state_nxt = S_RECOV;
            S_RECOV:  if (last)  state_nxt = S_IDLE;
            default:             state_nxt = S_IDLE;
        endcase
        if (state_nxt != state)
            cnt_nxt = load_val(state_nxt);
        else if (state != S_IDLE)
            cnt_nxt = cnt - 8'd1;
    end

    // Pins are decoded from the next state and registered, so they are flop outputs
    // that change on the same edge as the state; the address comes straight from
    // addr_i on the accepting edge because addr_q is loaded on that same edge.
    always_comb begin
        addr_src = (state == S_IDLE) ? addr_i : addr_q;
        busy_d   = (state_nxt != S_IDLE);
        done_d   = (state == S_RECOV) && (state_nxt == S_IDLE);
        cs_n_d   = 1'b1;
        as_d     = 1'b0;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        ad_oe_d  = 1'b0;
        ad_d     = '0;
        case (state_nxt)
            S_ADDR: begin
                cs_n_d  = 1'b0;
                as_d    = 1'b1;
                ad_oe_d = 1'b1;
                ad_d    = addr_src;
            end
            S_AHOLD: begin
                cs_n_d  = 1'b0;
                ad_oe_d = 1'b1;
                ad_d    = addr_src;
            end
            S_STROBE: begin
                cs_n_d = 1'b0;
                if (we_q) begin
                    wr_n_d  = 1'b0;
                    ad_oe_d = 1'b1;
                    ad_d    = wdata_q;
                end else begin
                    rd_n_d = 1'b0;
                end
            end
            S_DHOLD: begin
                cs_n_d = 1'b0;
                if (we_q) begin
                    ad_oe_d = 1'b1;
                    ad_d    = wdata_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= S_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            rdata_o <= '0;
            ad_o    <= '0;
            ad_oe_o <= 1'b0;
            as_o    <= 1'b0;
            cs_n_o  <= 1'b1;
            rd_n_o  <= 1'b1;
            wr_n_o  <= 1'b1;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            busy_o  <= busy_d;
            done_o  <= done_d;
            ad_o    <= ad_d;
            ad_oe_o <= ad_oe_d;
            as_o    <= as_d;
            cs_n_o  <= cs_n_d;
            rd_n_o  <= rd_n_d;
            wr_n_o  <= wr_n_d;
            if (state == S_IDLE && req_i) begin
                we_q    <= we_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
            end
            if (state == S_STROBE && last && !we_q)
                rdata_o <= ad_i;
        end
    end

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// Self-checking bench for rtc_bus_cycle: scoreboarded transactions with a per-cycle pin
// model on a default-timing instance, plus a short run on an all-ones-timing instance.
module tb_rtc_bus_cycle;

    localparam int TA = 5, TH = 2, TS = 15, TD = 3, TR = 20;
    localparam int N  = TA + TH + TS + TD + TR;

    typedef struct {
        int         start;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } txn_t;

    logic       clk = 1'b0;
    logic       reset_n;
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] last_rd = '0;
    txn_t       q[$];
    txn_t       q1[$];

    logic       req, we, busy, done, ad_oe, as_p, cs_n, rd_n, wr_n;
    logic [7:0] addr, wdata, rdata, ad, ad_in, rd_val;

    logic       req1, we1, busy1, done1, ad_oe1, as1, cs_n1, rd_n1, wr_n1;
    logic [7:0] addr1, wdata1, rdata1, ad1, ad_in1, rd_val1;

    assign ad_in  = rd_n  ? 8'hFF : rd_val;
    assign ad_in1 = rd_n1 ? 8'hFF : rd_val1;

    rtc_bus_cycle #(.T_ADDR(TA), .T_AH(TH), .T_STB(TS), .T_DH(TD), .T_REC(TR)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .busy_o(busy), .done_o(done), .rdata_o(rdata), .ad_o(ad),
        .ad_oe_o(ad_oe), .ad_i(ad_in), .as_o(as_p), .cs_n_o(cs_n), .rd_n_o(rd_n),
        .wr_n_o(wr_n)
    );

    rtc_bus_cycle #(.T_ADDR(1), .T_AH(1), .T_STB(1), .T_DH(1), .T_REC(1)) dut1 (
        .clk_i(clk), .reset_n_i(reset_n), .req_i(req1), .we_i(we1), .addr_i(addr1),
        .wdata_i(wdata1), .busy_o(busy1), .done_o(done1), .rdata_o(rdata1), .ad_o(ad1),
        .ad_oe_o(ad_oe1), .ad_i(ad_in1), .as_o(as1), .cs_n_o(cs_n1), .rd_n_o(rd_n1),
        .wr_n_o(wr_n1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_vec++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp_v, $time);
        end
    endtask

    // {busy, done, cs_n, as, rd_n, wr_n, ad_oe, ad[7:0]}
    localparam logic [14:0] PINS_IDLE = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};

    function automatic logic [14:0] pins_at(input int k, input txn_t t);
        logic cs_v, as_v, rd_v, wr_v, oe_v;
        logic [7:0] ad_v;
        bit in_stb, in_data;
        in_stb  = (k > TA + TH) && (k <= TA + TH + TS);
        in_data = (k > TA + TH) && (k <= TA + TH + TS + TD);
        cs_v = !(k <= TA + TH + TS + TD);
        as_v = (k <= TA);
        rd_v = !(in_stb && !t.we);
        wr_v = !(in_stb && t.we);
        oe_v = (k <= TA + TH) || (in_data && t.we);
        ad_v = (k <= TA + TH) ? t.addr : ((in_data && t.we) ? t.wdata : 8'h00);
        return {1'b1, 1'b0, cs_v, as_v, rd_v, wr_v, oe_v, ad_v};
    endfunction

    always @(negedge clk) begin
        logic [14:0] got, expv;
        int k;
        txn_t t;
        got  = {busy, done, cs_n, as_p, rd_n, wr_n, ad_oe, ad};
        expv = PINS_IDLE;
        if (q.size() > 0) begin
            k = cyc - q[0].start + 1;
            if (k >= 1 && k <= N) expv = pins_at(k, q[0]);
            else if (k == N + 1) expv[13] = 1'b1;
        end
        check("pins", {17'b0, got}, {17'b0, expv});
        if (done) begin
            if (q.size() == 0) begin
                check("spurious_done", {31'b0, done}, 32'd0);
            end else begin
                t = q.pop_front();
                check("done_cycle", cyc - t.start + 1, N + 1);
                if (!t.we) begin
                    check("rdata", {24'b0, rdata}, {24'b0, t.rdata});
                    last_rd = t.rdata;
                end else begin
                    check("rdata_hold", {24'b0, rdata}, {24'b0, last_rd});
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] wd,
                         input logic [7:0] rv, input bit hold);
        txn_t t;
        we = w; addr = a; wdata = wd; rd_val = rv; req = 1'b1;
        @(posedge clk); #1;
        t.start = cyc; t.we = w; t.addr = a; t.wdata = wd; t.rdata = rv;
        q.push_back(t);
        if (hold) begin
            t.start = cyc + N + 1;
            q.push_back(t);
            repeat (N + 1) @(posedge clk);
            #1;
        end
        req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (q.size() == 0) break;
        end
        if (q.size() != 0) begin
            check("timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic p1_run(input logic w, input logic [7:0] a, input logic [7:0] wd,
                          input logic [7:0] rv);
        txn_t t;
        int   k;
        bit   seen;
        we1 = w; addr1 = a; wdata1 = wd; rd_val1 = rv; req1 = 1'b1;
        @(posedge clk); #1;
        t.start = cyc; t.we = w; t.addr = a; t.wdata = wd; t.rdata = rv;
        q1.push_back(t);
        req1 = 1'b0;
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            k = cyc - q1[0].start + 1;
            if (k == 3) begin
                check("p1_strobe", {30'b0, rd_n1, wr_n1}, w ? 32'd2 : 32'd1);
                check("p1_ad", {23'b0, ad_oe1, ad1}, w ? {23'b0, 1'b1, wd} : 32'd0);
            end
            if (done1) begin
                t = q1.pop_front();
                check("p1_done_cycle", k, 6);
                if (!t.we) check("p1_rdata", {24'b0, rdata1}, {24'b0, t.rdata});
                seen = 1;
            end
        end
        if (!seen) begin
            check("p1_timeout", q1.size(), 0);
            q1.delete();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; rd_val = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; rd_val1 = 8'h00;
        #12;
        check("rst_rdata", {24'b0, rdata}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        #10 reset_n = 1'b1;
        @(posedge clk); #1;

        issue(1'b1, 8'h21, 8'h45, 8'h00, 0);
        wait_idle();
        issue(1'b0, 8'h04, 8'h00, 8'h37, 0);
        wait_idle();

        // request pulsed in cycle 10 of a write must be ignored
        issue(1'b1, 8'h5A, 8'hC3, 8'h00, 0);
        repeat (9) @(posedge clk);
        #1 req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        wait_idle();
        repeat (N + 5) @(negedge clk);

        // held request: second cycle starts right after the done cycle
        issue(1'b0, 8'h10, 8'h00, 8'h9C, 1);
        wait_idle();
        repeat (3) @(negedge clk);

        // reset in the middle of the write strobe
        issue(1'b1, 8'h77, 8'hA5, 8'h00, 0);
        repeat (11) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("arst_pins", {17'b0, busy, done, cs_n, as_p, rd_n, wr_n, ad_oe, ad},
              {17'b0, PINS_IDLE});
        check("arst_rdata", {24'b0, rdata}, 32'd0);
        q.delete();
        last_rd = '0;
        #4 reset_n = 1'b1;
        repeat (N + 5) @(negedge clk);

        issue(1'b1, 8'h33, 8'h66, 8'h00, 0);
        wait_idle();
        issue(1'b0, 8'h3C, 8'h00, 8'h5E, 0);
        wait_idle();

        p1_run(1'b1, 8'h0B, 8'h82, 8'h00);
        repeat (2) @(negedge clk);
        p1_run(1'b0, 8'h0C, 8'h00, 8'hD4);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rtc_bus_cycle.md
# rtc_bus_cycle

Bus-cycle engine between the RTC sequencing logic (init/write/read machines) and the external RTC chip pins. It turns a single-cycle register request (address, write data, direction) into a timed Intel-style multiplexed address/data cycle: chip select, address strobe, then read or write strobe, then recovery. It returns read data with a one-cycle done pulse. The top level builds the bidirectional pad from `ad_o`/`ad_oe_o`/`ad_i`.

## Interface

Parameters (cycle counts, legal range 1..255; 0 behaves as 1):
- `T_ADDR`, 5: address phase length; `as_o` high, address driven.
- `T_AH`, 2: address hold after `as_o` falls.
- `T_STB`, 15: `rd_n_o`/`wr_n_o` low time.
- `T_DH`, 3: data hold after strobe rises, `cs_n_o` still low.
- `T_REC`, 20: recovery with `cs_n_o` high before the next cycle.

Ports:
- `clk_i`, in, 1: system clock, 100 MHz.
- `reset_n_i`, in, 1: reset, asynchronous, active-low.
- `req_i`, in, 1: start request; sampled only in IDLE.
- `we_i`, in, 1: 1 = write, 0 = read; captured with `req_i`.
- `addr_i`, in, 8: RTC register address; captured.
- `wdata_i`, in, 8: write data; captured.
- `busy_o`, out, 1: a transaction is in progress.
- `done_o`, out, 1: one-cycle completion pulse.
- `rdata_o`, out, 8: last read data; held until the next read completes.
- `ad_o`, out, 8: value driven on the AD bus.
- `ad_oe_o`, out, 1: AD bus output enable.
- `ad_i`, in, 8: AD bus input.
- `as_o`, out, 1: address strobe, active-high.
- `cs_n_o`, `rd_n_o`, `wr_n_o`, out, 1 each: chip select, read strobe and write strobe, all active-low.

## Operation

- FSM states: IDLE, ADDR, AHOLD, STROBE, DHOLD, RECOV. An 8-bit down-counter loads the parameter value on each state entry, and the state advances when the counter reaches 1.
- IDLE: `cs_n_o`=`rd_n_o`=`wr_n_o`=1, `as_o`=0, `ad_oe_o`=0, `busy_o`=0. If `req_i`=1 at an edge, capture `we_i`/`addr_i`/`wdata_i` and go to ADDR.
- ADDR: `cs_n_o`=0, `as_o`=1, `ad_oe_o`=1, `ad_o`=addr.
- AHOLD: `as_o`=0; `ad_o`=addr still driven.
- STROBE:
  - Write: `wr_n_o`=0, `ad_o`=wdata, `ad_oe_o`=1.
  - Read: `rd_n_o`=0, `ad_oe_o`=0.
  - Read capture: `ad_i` is registered into `rdata_o` at the edge that ends the last STROBE cycle.
- DHOLD: strobes are high.
  - Write: keeps wdata driven.
  - Read: keeps `ad_oe_o`=0.
  - `cs_n_o` stays 0.
- RECOV: `cs_n_o`=1, `ad_oe_o`=0, `as_o`=0.
- Exit: after RECOV the FSM returns to IDLE with `done_o`=1 for that first IDLE cycle.
- `ad_o` is 0 whenever `ad_oe_o`=0.
- Requests while busy: `req_i` is ignored in every non-IDLE state (no queueing). A request in the done cycle is accepted, which gives back-to-back cycles.
- All pin outputs are driven from flops; no combinational path from `req_i` to the pins.
- Reset (any time, including mid-strobe), asynchronously forces:
  - State IDLE, `cs_n_o`=`rd_n_o`=`wr_n_o`=1.
  - `as_o`=0, `ad_oe_o`=0, `ad_o`=0.
  - `busy_o`=0, `done_o`=0, `rdata_o`=0.
  - The aborted transaction produces no `done_o`.

## Timing

- Request accepted at edge E0. Pins change after E0:
  - `busy_o`=1 and ADDR outputs are valid in cycle 1.
  - Stays busy for T_ADDR+T_AH+T_STB+T_DH+T_REC cycles.
  - `done_o` and `busy_o`=0 appear in cycle N+1, where N is that sum.
  - Defaults: N=45, so `done_o` is in cycle 46.
- `as_o` high for exactly T_ADDR cycles; address stable T_AH cycles after `as_o` falls.
- Strobe low for exactly T_STB cycles. `cs_n_o` low for T_ADDR+T_AH+T_STB+T_DH cycles, enclosing the strobe.
- Read data sampled T_STB cycles after the strobe falls, which is the final low cycle. `rdata_o` is valid from the `done_o` cycle.
- Minimum req-to-req spacing: N+1 cycles.
- All parameters = 1: N=5, `done_o` in cycle 6.

## Test plan

- Reset: assert `reset_n_i`=0 mid-run. Expected: all outputs at their reset values immediately, without waiting for a clock edge; `busy_o`=0.
- Write, addr 0x21, data 0x45, defaults:
  - `as_o`=1 for 5 cycles with `ad_o`=0x21.
  - `wr_n_o`=0 for 15 cycles with `ad_o`=0x45, `ad_oe_o`=1; `rd_n_o` stays 1.
  - `done_o` pulse in cycle 46.
- Read, addr 0x04: bench drives `ad_i`=0x37 while `rd_n_o`=0, then 0xFF after `rd_n_o` rises. Expected: `rdata_o`=0x37 at `done_o`; `ad_oe_o`=0 throughout STROBE and DHOLD.
- `req_i` pulsed in cycle 10 of a transaction: ignored, one `done_o` only.
  - `req_i` held high: the second cycle's `as_o` rises in the cycle after `done_o`.
  - `cs_n_o` high for exactly 20 cycles plus the done cycle between the two transactions.
- Reset during STROBE of a write: `wr_n_o`/`cs_n_o` go to 1 and `ad_oe_o` to 0 asynchronously. No `done_o`. The next request completes normally.
- All parameters = 1, write then read: `done_o` in cycle 6 each; `rdata_o` captures `ad_i` from the single strobe cycle.
